// File: rtl/maze_pkg.sv
// Shared types and constants for the maze cell store and its arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package maze_pkg;

    localparam int GRID_W    = 3;
    localparam int GRID_H    = 3;
    localparam int CELL_W    = 1;
    localparam int NUM_CELLS = GRID_W * GRID_H;
    localparam int ADDR_W    = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;

    localparam logic [CELL_W-1:0] CELL_WALL = CELL_W'(1);
    localparam logic [CELL_W-1:0] CELL_OPEN = CELL_W'(0);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Flat cell address: row-major layout.
    function automatic logic [ADDR_W-1:0] cell_addr(input int unsigned row, input int unsigned col);
        return ADDR_W'(row * GRID_W + col);
    endfunction

endpackage

// File: rtl/maze_cell_arbiter_if.sv
// Bundle of renderer, update and clear signals between the clients and the cell arbiter.
// Latency: n/a (wiring only).
// Backpressure: update side is a req/gnt level handshake; renderer side never stalls.
// Ports: master = client side (renderer, game logic, vblank source); slave = arbiter.
interface maze_cell_arbiter_if;
    import maze_pkg::*;

    logic              vblank;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [CELL_W-1:0] r_data;
    logic              r_valid;
    logic              u_req;
    logic              u_we;
    logic [ADDR_W-1:0] u_addr;
    logic [CELL_W-1:0] u_wdata;
    logic              u_gnt;
    logic              u_done;
    logic [CELL_W-1:0] u_rdata;
    logic              clr_req;
    logic              clr_busy;
    logic              u_starve;

    modport master (
        output vblank, r_req, r_addr, u_req, u_we, u_addr, u_wdata, clr_req,
        input  r_data, r_valid, u_gnt, u_done, u_rdata, clr_busy, u_starve
    );

    modport slave (
        input  vblank, r_req, r_addr, u_req, u_we, u_addr, u_wdata, clr_req,
        output r_data, r_valid, u_gnt, u_done, u_rdata, clr_busy, u_starve
    );

endinterface

// File: rtl/maze_cell_ram.sv
// Single-port cell array: synchronous read, out-of-range reads return 0, out-of-range writes dropped.
// Latency: read data appears the cycle after en with we = 0; writes commit at the clock edge.
// Backpressure: none; one access per cycle, chosen by the caller.
// Ports: clk, en, we, addr, wdata in; rdata out (holds between reads).
module maze_cell_ram
    import maze_pkg::*;
(
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [CELL_W-1:0] wdata,
    output logic [CELL_W-1:0] rdata
);

    logic [CELL_W-1:0] mem [NUM_CELLS];
    logic              in_range;

    assign in_range = (int'(addr) < NUM_CELLS);

    // No reset: cell contents and the read register survive reset by design.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                if (in_range) begin
                    mem[addr] <= wdata;
                end
            end else begin
                rdata <= in_range ? mem[addr] : '0;
            end
        end
    end

endmodule

// File: rtl/maze_cell_arbiter.sv
// Shares the cell store port: renderer > bulk clear (vblank only) > game update.
// Latency: renderer read 1 cycle fixed; update gnt combinational in accept cycle, done 1 cycle later.
// Backpressure: update waits on u_gnt (u_starve after MAX_WAIT cycles); clear pauses outside vblank.
// Ports: clk, reset (sync, active-low), bus (slave modport of maze_cell_arbiter_if).
module maze_cell_arbiter
    import maze_pkg::*;
#(
    parameter logic [CELL_W-1:0] CLR_VAL  = CELL_OPEN,
    parameter int                MAX_WAIT = 1023
) (
    input  logic               clk,
    input  logic               reset,
    maze_cell_arbiter_if.slave bus
);

    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CELLS - 1);

    clr_state_t        state, state_nxt;
    logic [ADDR_W-1:0] clr_idx;
    logic              clr_own, upd_own, clr_busy;

    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [CELL_W-1:0] ram_wdata, ram_rdata;

    logic              r_valid_q, u_done_q, u_rd_q, u_starve_q;
    logic [CELL_W-1:0] u_rdata_hold;
    logic [WAIT_W-1:0] wait_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.clr_req) state_nxt = CLEAR;
            CLEAR:   if (clr_own && clr_idx == LAST_IDX) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Port ownership; everything is gated by reset so no access happens in a reset cycle.
    // clr_req in IDLE takes precedence over a pending update.
    always_comb begin
        clr_busy = (state == CLEAR);
        clr_own  = reset && (state == CLEAR) && bus.vblank && !bus.r_req;
        upd_own  = reset && (state == IDLE) && !bus.r_req && bus.u_req && !bus.clr_req;
    end

    always_ff @(posedge clk) begin
        if (!reset || state == IDLE) begin
            clr_idx <= '0;
        end else if (clr_own) begin
            clr_idx <= (clr_idx == LAST_IDX) ? '0 : clr_idx + 1'b1;
        end
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (reset && bus.r_req) begin
            ram_en   = 1'b1;
            ram_addr = bus.r_addr;
        end else if (clr_own) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = clr_idx;
            ram_wdata = CLR_VAL;
        end else if (upd_own) begin
            ram_en    = 1'b1;
            ram_we    = bus.u_we;
            ram_addr  = bus.u_addr;
            ram_wdata = bus.u_wdata;
        end
    end

    maze_cell_ram u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid_q    <= 1'b0;
            u_done_q     <= 1'b0;
            u_rd_q       <= 1'b0;
            u_rdata_hold <= '0;
        end else begin
            r_valid_q <= bus.r_req;
            u_done_q  <= upd_own;
            u_rd_q    <= upd_own && !bus.u_we;
            if (u_done_q && u_rd_q) u_rdata_hold <= ram_rdata;
        end
    end

    // Wait counter saturates; the starve pulse fires only on the step into MAX_WAIT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt   <= '0;
            u_starve_q <= 1'b0;
        end else if (bus.u_req && !upd_own) begin
            if (wait_cnt != WAIT_W'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
            u_starve_q <= (wait_cnt == WAIT_W'(MAX_WAIT - 1));
        end else begin
            wait_cnt   <= '0;
            u_starve_q <= 1'b0;
        end
    end

    // The RAM read register is shared, so each output only looks at it in its own done/valid cycle.
    assign bus.r_valid  = r_valid_q;
    assign bus.r_data   = r_valid_q ? ram_rdata : '0;
    assign bus.u_gnt    = upd_own;
    assign bus.u_done   = u_done_q;
    assign bus.u_rdata  = (u_done_q && u_rd_q) ? ram_rdata : u_rdata_hold;
    assign bus.clr_busy = clr_busy;
    assign bus.u_starve = u_starve_q;

endmodule

// File: tb/tb_maze_cell_arbiter.sv
// Bench for maze_cell_arbiter: directed scenarios followed by random traffic.
// Latency: n/a. Backpressure: requester holds u_req until u_gnt.
// Every cycle all outputs are compared against a cell-array reference model.
module tb_maze_cell_arbiter;
    import maze_pkg::*;

    localparam int MAXW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    maze_cell_arbiter_if bus();

    maze_cell_arbiter #(.CLR_VAL(CELL_OPEN), .MAX_WAIT(MAXW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [CELL_W-1:0] m_mem [NUM_CELLS];
    bit                m_clearing;
    int                m_idx, m_wait;
    logic              m_rvalid, m_done, m_starve;
    logic [CELL_W-1:0] m_rdata, m_urdata;
    logic              last_gnt, obs_gnt, obs_starve;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CELL_W-1:0] model_rd(input logic [ADDR_W-1:0] a);
        if (int'(a) < NUM_CELLS) return m_mem[int'(a)];
        return '0;
    endfunction

    // One clock cycle: inputs already applied; compare, advance the model, step the clock.
    task automatic cycle();
        logic g;
        #1;
        g = reset && !m_clearing && !bus.r_req && bus.u_req && !bus.clr_req;
        chk("r_valid",  bus.r_valid,  m_rvalid);
        chk("r_data",   bus.r_data,   m_rdata);
        chk("u_done",   bus.u_done,   m_done);
        chk("u_rdata",  bus.u_rdata,  m_urdata);
        chk("u_starve", bus.u_starve, m_starve);
        chk("u_gnt",    bus.u_gnt,    g);
        chk("clr_busy", bus.clr_busy, m_clearing);
        obs_gnt    = bus.u_gnt;
        obs_starve = bus.u_starve;
        if (!reset) begin
            m_clearing = 0; m_idx = 0; m_wait = 0;
            m_rvalid = 0; m_rdata = '0; m_done = 0; m_urdata = '0; m_starve = 0;
        end else begin
            m_rvalid = bus.r_req;
            m_rdata  = bus.r_req ? model_rd(bus.r_addr) : '0;
            m_done   = g;
            if (g && !bus.u_we) m_urdata = model_rd(bus.u_addr);
            if (g && bus.u_we && int'(bus.u_addr) < NUM_CELLS) m_mem[int'(bus.u_addr)] = bus.u_wdata;
            if (m_clearing) begin
                if (bus.vblank && !bus.r_req) begin
                    m_mem[m_idx] = CELL_OPEN;
                    m_idx++;
                    if (m_idx == NUM_CELLS) begin m_clearing = 0; m_idx = 0; end
                end
            end else if (bus.clr_req) begin
                m_clearing = 1; m_idx = 0;
            end
            if (bus.u_req && !g) begin
                if (m_wait < MAXW) begin
                    m_wait++;
                    m_starve = (m_wait == MAXW);
                end else begin
                    m_starve = 0;
                end
            end else begin
                m_wait = 0; m_starve = 0;
            end
        end
        last_gnt = g;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.vblank = 0; bus.r_req = 0; bus.r_addr = '0;
        bus.u_req = 0; bus.u_we = 0; bus.u_addr = '0; bus.u_wdata = '0;
        bus.clr_req = 0;
    endtask

    task automatic upd(input logic we, input logic [ADDR_W-1:0] a, input logic [CELL_W-1:0] d);
        int n;
        bus.u_req = 1; bus.u_we = we; bus.u_addr = a; bus.u_wdata = d;
        n = 0;
        do begin cycle(); n++; end while (!last_gnt && n < 64);
        chk("upd_gnt", obs_gnt, 1);
        bus.u_req = 0;
        cycle();
    endtask

    task automatic fill(input logic [CELL_W-1:0] d);
        for (int a = 0; a < NUM_CELLS; a++) upd(1'b1, ADDR_W'(a), d);
    endtask

    task automatic read_cell(input logic [ADDR_W-1:0] a, input logic [CELL_W-1:0] exp, input string tag);
        bus.r_req = 1; bus.r_addr = a;
        cycle();
        chk({tag, "_vld"}, bus.r_valid, 1);
        chk(tag, bus.r_data, exp);
        bus.r_req = 0;
    endtask

    task automatic pulse_clr();
        bus.clr_req = 1;
        cycle();
        bus.clr_req = 0;
    endtask

    initial begin
        int n, g, sp, st;
        reset = 0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        m_clearing = 0; m_idx = 0; m_wait = 0;
        m_rvalid = 0; m_rdata = '0; m_done = 0; m_urdata = '0; m_starve = 0;
        last_gnt = 0; obs_gnt = 0; obs_starve = 0;
        reset = 1;
        cycle();                                   // reset values

        for (int a = 0; a < NUM_CELLS; a++) upd(1'b1, ADDR_W'(a), CELL_W'($urandom_range(0, 1)));

        // Renderer latency and out-of-range read
        upd(1'b1, cell_addr(1, 1), CELL_WALL);
        read_cell(cell_addr(1, 1), CELL_WALL, "lat_cell4");
        read_cell(ADDR_W'(12), CELL_OPEN, "lat_oob");

        // Renderer beats update
        bus.r_req = 1; bus.r_addr = '0;
        bus.u_req = 1; bus.u_we = 1; bus.u_addr = ADDR_W'(2); bus.u_wdata = CELL_WALL;
        g = 0;
        repeat (5) begin cycle(); g += int'(obs_gnt); end
        chk("prio_no_gnt", g, 0);
        bus.r_req = 0;
        cycle();
        chk("prio_gnt", obs_gnt, 1);
        bus.u_req = 0;
        chk("prio_done", bus.u_done, 1);
        read_cell(ADDR_W'(2), CELL_WALL, "prio_cell2");

        // Full clear sequence
        fill(CELL_WALL);
        bus.vblank = 1;
        pulse_clr();
        chk("clr_busy_rise", bus.clr_busy, 1);
        n = 0;
        while (bus.clr_busy && n < 32) begin cycle(); n++; end
        chk("clr_len", n, NUM_CELLS);
        for (int a = 0; a < NUM_CELLS; a++) read_cell(ADDR_W'(a), CELL_OPEN, "clr_cell");

        // Clear paused by end of blanking, update held off the whole time
        fill(CELL_WALL);
        bus.vblank = 1;
        pulse_clr();
        bus.u_req = 1; bus.u_we = 1; bus.u_addr = ADDR_W'(8); bus.u_wdata = CELL_OPEN;
        g = 0;
        repeat (4) begin cycle(); g += int'(obs_gnt); end
        bus.vblank = 0;
        repeat (3) begin cycle(); g += int'(obs_gnt); end
        chk("pause_busy", bus.clr_busy, 1);
        read_cell(ADDR_W'(3), CELL_OPEN, "pause_c3");
        g += int'(obs_gnt);
        read_cell(ADDR_W'(4), CELL_WALL, "pause_c4");
        g += int'(obs_gnt);
        bus.vblank = 1;
        n = 0;
        while (bus.clr_busy && n < 32) begin cycle(); g += int'(obs_gnt); n++; end
        chk("pause_rest", n, 5);
        chk("pause_no_gnt", g, 0);
        cycle();
        chk("pause_gnt_after", obs_gnt, 1);
        bus.u_req = 0;
        cycle();

        // Starvation pulse while the renderer hogs the port
        bus.r_req = 1; bus.r_addr = ADDR_W'(7);
        bus.u_req = 1; bus.u_we = 0; bus.u_addr = ADDR_W'(5);
        sp = 0; st = -1; g = 0;
        for (int j = 0; j < 12; j++) begin
            cycle();
            g += int'(obs_gnt);
            if (obs_starve) begin sp++; st = j; end
        end
        chk("starve_pulses", sp, 1);
        chk("starve_cycle", st, MAXW);
        chk("starve_no_gnt", g, 0);
        bus.r_req = 0;
        cycle();
        chk("starve_gnt", obs_gnt, 1);
        bus.u_req = 0;
        cycle();

        // Reset in the middle of a clear
        fill(CELL_WALL);
        bus.vblank = 1;
        pulse_clr();
        repeat (3) cycle();
        reset = 0;
        cycle();
        reset = 1;
        chk("rst_busy", bus.clr_busy, 0);
        for (int a = 0; a < NUM_CELLS; a++)
            read_cell(ADDR_W'(a), (a < 3) ? CELL_OPEN : CELL_WALL, "rst_cell");
        pulse_clr();
        chk("reclr_busy", bus.clr_busy, 1);
        n = 0;
        while (bus.clr_busy && n < 32) begin cycle(); n++; end
        chk("reclr_len", n, NUM_CELLS);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            bus.r_req   = ($urandom_range(0, 2) == 0);
            bus.r_addr  = ADDR_W'($urandom_range(0, 15));
            bus.vblank  = ($urandom_range(0, 1) == 1);
            bus.clr_req = ($urandom_range(0, 29) == 0);
            reset       = ($urandom_range(0, 79) != 0);
            if (!bus.u_req && $urandom_range(0, 1) == 1) begin
                bus.u_req   = 1;
                bus.u_we    = ($urandom_range(0, 1) == 1);
                bus.u_addr  = ADDR_W'($urandom_range(0, 15));
                bus.u_wdata = CELL_W'($urandom_range(0, 1));
            end
            cycle();
            if (last_gnt) bus.u_req = 0;
        end
        reset = 1;
        set_idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
